// File: rtl/microseq_ctrl.sv
// microseq_ctrl -- microprogram sequencer for the control unit.
//
// Holds the current control-store address (state) and computes the next one
// from the current word's next-address mode (n_sel), condition select (s_sel),
// invert bit (inv) and the two branch targets (cr_lo / cr_hi), plus status
// inputs.  state drives the IN address of the control ROM directly, so the
// ROM fields seen on the inputs are always those of the word at 'state'.
//
// Next-address modes (n_sel):
//   0 ENC  dispatch to enc_addr       4 BR2  cond ? cr_lo : cr_hi
//   1 INC  state+1                    5 CALL cr_lo, ret_addr <= state+1
//   2 JMP  cr_lo                      6 RET  ret_addr
//   3 CJ   cond ? cr_lo : state+1     7 WAIT cond ? state+1 : hold
//
// Condition select (s_sel): 0 moc, 1 cond_pass, 2 ir_l, 3 irq_pend,
//   4 lsm_done, 5 alu_z, 6 constant 1, 7 constant 0.  cond_eff = cond ^ inv.
//
// Build option: define MICROSEQ_WATCHDOG_EN to add a WAIT-hold watchdog.
//   A hold counter increments on every WAIT hold cycle and clears on any
//   other advance. When a hold is pending and the count already equals
//   WDOG_LIMIT, state is forced to ABORT_ADDR and wdog_abort pulses for one
//   cycle. Without the macro WAIT may hold forever and wdog_abort is 0.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous reset, active-low (priority over stall)
//   stall      in   freeze: state, ret_addr and watchdog count hold
//   n_sel      in   [2:0] next-address mode
//   inv        in   invert selected condition
//   s_sel      in   [2:0] condition select
//   cr_hi      in   [AW-1:0] alternate target
//   cr_lo      in   [AW-1:0] primary target
//   enc_addr   in   [AW-1:0] instruction-decoder dispatch address
//   moc, cond_pass, ir_l, irq_pend, lsm_done, alu_z   in   status inputs
//   state      out  [AW-1:0] registered control-store address
//   ret_addr   out  [AW-1:0] registered return address
//   cond_eff   out  combinational selected condition XOR inv
//   wdog_abort out  registered one-cycle watchdog pulse
module microseq_ctrl #(
  parameter int unsigned    AW         = 8,
  parameter logic [AW-1:0]  RESET_ADDR = '0,
  parameter int unsigned    WDOG_LIMIT = 15,
  parameter logic [AW-1:0]  ABORT_ADDR = AW'(6)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic [2:0]    n_sel,
  input  logic          inv,
  input  logic [2:0]    s_sel,
  input  logic [AW-1:0] cr_hi,
  input  logic [AW-1:0] cr_lo,
  input  logic [AW-1:0] enc_addr,
  input  logic          moc,
  input  logic          cond_pass,
  input  logic          ir_l,
  input  logic          irq_pend,
  input  logic          lsm_done,
  input  logic          alu_z,
  output logic [AW-1:0] state,
  output logic [AW-1:0] ret_addr,
  output logic          cond_eff,
  output logic          wdog_abort
);

  typedef enum logic [2:0] {
    N_ENC  = 3'd0,
    N_INC  = 3'd1,
    N_JMP  = 3'd2,
    N_CJ   = 3'd3,
    N_BR2  = 3'd4,
    N_CALL = 3'd5,
    N_RET  = 3'd6,
    N_WAIT = 3'd7
  } nmode_e;

  nmode_e        mode;
  logic          cond;
  logic [AW-1:0] state_inc;
  logic [AW-1:0] state_nxt;
  logic [AW-1:0] ret_nxt;
  logic          expire;

  assign mode = nmode_e'(n_sel);

  // Condition multiplexer
  always_comb begin
    cond = 1'b0;
    case (s_sel)
      3'd0: cond = moc;
      3'd1: cond = cond_pass;
      3'd2: cond = ir_l;
      3'd3: cond = irq_pend;
      3'd4: cond = lsm_done;
      3'd5: cond = alu_z;
      3'd6: cond = 1'b1;
      3'd7: cond = 1'b0;
    endcase
  end

  assign cond_eff  = cond ^ inv;
  assign state_inc = state + AW'(1);   // wraps modulo 2^AW

  // Next-address selection
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_addr;
    case (mode)
      N_ENC:  state_nxt = enc_addr;
      N_INC:  state_nxt = state_inc;
      N_JMP:  state_nxt = cr_lo;
      N_CJ:   state_nxt = cond_eff ? cr_lo : state_inc;
      N_BR2:  state_nxt = cond_eff ? cr_lo : cr_hi;
      N_CALL: begin
        state_nxt = cr_lo;
        ret_nxt   = state_inc;
      end
      N_RET:  state_nxt = ret_addr;
      N_WAIT: state_nxt = cond_eff ? state_inc : state;
    endcase
  end

`ifdef MICROSEQ_WATCHDOG_EN
  localparam int unsigned CW = ($clog2(WDOG_LIMIT + 1) > 4) ? $clog2(WDOG_LIMIT + 1) : 4;

  logic          hold;
  logic [CW-1:0] wdog_cnt;
  logic [CW-1:0] wdog_cnt_nxt;

  // Expiry fires on the hold that would exceed the limit, replacing it.
  always_comb begin
    hold         = (mode == N_WAIT) && !cond_eff;
    expire       = hold && (wdog_cnt == CW'(WDOG_LIMIT));
    wdog_cnt_nxt = '0;
    if (hold && !expire) begin
      wdog_cnt_nxt = wdog_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt   <= '0;
      wdog_abort <= 1'b0;
    end else if (stall) begin
      wdog_abort <= 1'b0;
    end else begin
      wdog_cnt   <= wdog_cnt_nxt;
      wdog_abort <= expire;
    end
  end
`else
  assign expire     = 1'b0;
  assign wdog_abort = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= RESET_ADDR;
      ret_addr <= '0;
    end else if (!stall) begin
      state    <= expire ? ABORT_ADDR : state_nxt;
      ret_addr <= ret_nxt;
    end
  end

endmodule
